// File: rtl/bsa_pkg.sv
// rtl/bsa_pkg.sv - shared encodings for the barrel shift arbiter
// Mode and direction constants plus the result-buffer state type.
package bsa_pkg;

   localparam logic [1:0] MODE_LOGIC   = 2'b00;
   localparam logic [1:0] MODE_ARITH   = 2'b01;
   localparam logic [1:0] MODE_ROT     = 2'b10;
   localparam logic [1:0] MODE_ILLEGAL = 2'b11;

   localparam logic DIR_LEFT  = 1'b1;
   localparam logic DIR_RIGHT = 1'b0;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

endpackage

// File: rtl/barrel_shift_core.sv
// rtl/barrel_shift_core.sv - combinational shifter shared by all requesters
// Logical, arithmetic and rotate shifts in either direction; illegal mode passes through.
module barrel_shift_core
   import bsa_pkg::*;
#(
   parameter  int N  = 8,
   localparam int AW = $clog2(N)
) (
   input  logic [N-1:0]  d_in,
   input  logic [AW-1:0] sft_amt,
   input  logic          sft_dir,
   input  logic [1:0]    mode,
   output logic [N-1:0]  dout
);

   logic [AW:0]  rot_amt;
   logic [N-1:0] rot_out;

   // A right rotate by k is a left rotate by N-k; an amount of N shifts everything out of one term.
   always_comb begin
      rot_amt = (sft_dir == DIR_LEFT) ? {1'b0, sft_amt}
                                      : (AW+1)'(N) - {1'b0, sft_amt};
      rot_out = (d_in << rot_amt) | (d_in >> ((AW+1)'(N) - rot_amt));
   end

   always_comb begin
      dout = d_in;
      case (mode)
         MODE_LOGIC: dout = (sft_dir == DIR_LEFT) ? (d_in << sft_amt) : (d_in >> sft_amt);
         MODE_ARITH: dout = (sft_dir == DIR_LEFT) ? (d_in << sft_amt)
                                                  : N'($signed(d_in) >>> sft_amt);
         MODE_ROT:   dout = rot_out;
         default:    dout = d_in;
      endcase
   end

endmodule

// File: rtl/barrel_shift_arbiter.sv
// rtl/barrel_shift_arbiter.sv - arbitrated shared barrel shifter with a one-entry result buffer
// BSA_ROUND_ROBIN_EN selects round-robin arbitration; fixed lowest-index priority otherwise.
module barrel_shift_arbiter
   import bsa_pkg::*;
#(
   parameter  int N    = 8,
   parameter  int NREQ = 4,
   localparam int AW   = $clog2(N),
   localparam int IW   = $clog2(NREQ)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NREQ-1:0]    req_valid,
   output logic [NREQ-1:0]    req_ready,
   input  logic [NREQ*N-1:0]  req_data,
   input  logic [NREQ*AW-1:0] req_amt,
   input  logic [NREQ-1:0]    req_dir,
   input  logic [NREQ*2-1:0]  req_mode,
   output logic               res_valid,
   input  logic               res_ready,
   output logic [N-1:0]       res_data,
   output logic [IW-1:0]      res_id,
   output logic               res_err
);

   state_t        state_q, state_d;
   logic [N-1:0]  res_data_q, res_data_d;
   logic [IW-1:0] res_id_q, res_id_d;
   logic          res_err_q, res_err_d;

   logic          win_found;
   logic [IW-1:0] win_idx;
   logic          can_accept;
   logic          accept;
   logic [N-1:0]  sel_data;
   logic [AW-1:0] sel_amt;
   logic          sel_dir;
   logic [1:0]    sel_mode;
   logic [N-1:0]  shift_out;

`ifdef BSA_ROUND_ROBIN_EN
   logic [IW-1:0] ptr_q, ptr_d;
   logic [IW:0]   cand;

   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = {1'b0, ptr_q} + (IW+1)'(k);
         if (cand >= (IW+1)'(NREQ)) cand = cand - (IW+1)'(NREQ);
         if (!win_found && req_valid[cand[IW-1:0]]) begin
            win_found = 1'b1;
            win_idx   = cand[IW-1:0];
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (accept) ptr_d = (win_idx == IW'(NREQ-1)) ? '0 : win_idx + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) ptr_q <= '0;
      else     ptr_q <= ptr_d;
   end
`else
   // Scanning downward leaves the lowest valid index as the winner.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      for (int k = NREQ-1; k >= 0; k--) begin
         if (req_valid[k]) begin
            win_found = 1'b1;
            win_idx   = IW'(k);
         end
      end
   end
`endif

   always_comb begin
      sel_data = req_data[win_idx*N +: N];
      sel_amt  = req_amt[win_idx*AW +: AW];
      sel_dir  = req_dir[win_idx];
      sel_mode = req_mode[win_idx*2 +: 2];
   end

   barrel_shift_core #(.N(N)) u_core (
      .d_in    (sel_data),
      .sft_amt (sel_amt),
      .sft_dir (sel_dir),
      .mode    (sel_mode),
      .dout    (shift_out)
   );

   assign can_accept = (state_q == ST_EMPTY) || res_ready;

   always_comb begin
      req_ready = '0;
      if (win_found && can_accept && !rst) req_ready[win_idx] = 1'b1;
   end

   assign accept = |req_ready;

   always_comb begin
      state_d    = state_q;
      res_data_d = res_data_q;
      res_id_d   = res_id_q;
      res_err_d  = res_err_q;
      if (accept) begin
         state_d    = ST_FULL;
         res_data_d = shift_out;
         res_id_d   = win_idx;
         res_err_d  = (sel_mode == MODE_ILLEGAL);
      end else if (state_q == ST_FULL && res_ready) begin
         state_d = ST_EMPTY;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_EMPTY;
         res_data_q <= '0;
         res_id_q   <= '0;
         res_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         res_data_q <= res_data_d;
         res_id_q   <= res_id_d;
         res_err_q  <= res_err_d;
      end
   end

   assign res_valid = (state_q == ST_FULL);
   assign res_data  = res_data_q;
   assign res_id    = res_id_q;
   assign res_err   = res_err_q;

endmodule

// File: tb/tb_barrel_shift_arbiter.sv
// tb/tb_barrel_shift_arbiter.sv - self-checking bench for barrel_shift_arbiter
// Bit-level shift model and transaction-level buffer model, checked every falling edge.
module tb_barrel_shift_arbiter;

   localparam int N    = 8;
   localparam int NREQ = 4;

   logic             clk;
   logic             rst;
   logic [NREQ-1:0]  req_valid;
   logic [NREQ-1:0]  req_ready;
   logic [NREQ*N-1:0] req_data;
   logic [NREQ*3-1:0] req_amt;
   logic [NREQ-1:0]  req_dir;
   logic [NREQ*2-1:0] req_mode;
   logic             res_valid;
   logic             res_ready;
   logic [N-1:0]     res_data;
   logic [1:0]       res_id;
   logic             res_err;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] q_data[$];
   int         q_id[$];
   logic       q_err[$];

   bit         mdl_full;
   logic [7:0] mdl_data;
   int         mdl_id;
   bit         mdl_err;
   int         mdl_ptr;
   int         win;
   int         idx;
   logic [3:0] exp_ready;

   barrel_shift_arbiter #(.N(N), .NREQ(NREQ)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_data  (req_data),
      .req_amt   (req_amt),
      .req_dir   (req_dir),
      .req_mode  (req_mode),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .res_id    (res_id),
      .res_err   (res_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Each result bit is taken from the source bit it would land on after the shift.
   function automatic logic [7:0] model_shift(input logic [7:0] d, input int amt,
                                              input bit dir, input logic [1:0] mode);
      logic [7:0] r;
      int s;
      r = d;
      if (mode == 2'b11 || amt == 0) return d;
      for (int i = 0; i < 8; i++) begin
         if (mode == 2'b10) begin
            s = dir ? (i - amt + 8) % 8 : (i + amt) % 8;
            r[i] = d[s];
         end else if (dir) begin
            s = i - amt;
            r[i] = (s < 0) ? 1'b0 : d[s];
         end else begin
            s = i + amt;
            r[i] = (s > 7) ? ((mode == 2'b01) ? d[7] : 1'b0) : d[s];
         end
      end
      return r;
   endfunction

   always @(negedge clk) begin
      if (rst) begin
         check("rst_res_valid", res_valid, 0);
         check("rst_req_ready", req_ready, 0);
         check("rst_res_data", res_data, 0);
         check("rst_res_id", res_id, 0);
         check("rst_res_err", res_err, 0);
         mdl_full = 0;
         mdl_data = 0;
         mdl_id   = 0;
         mdl_err  = 0;
         mdl_ptr  = 0;
      end else begin
         win = -1;
         for (int k = 0; k < NREQ; k++) begin
`ifdef BSA_ROUND_ROBIN_EN
            idx = (mdl_ptr + k) % NREQ;
`else
            idx = k;
`endif
            if (win < 0 && req_valid[idx]) win = idx;
         end
         exp_ready = 4'b0000;
         if (win >= 0 && (!mdl_full || res_ready)) exp_ready[win] = 1'b1;
         check("req_ready", req_ready, exp_ready);
         check("res_valid", res_valid, mdl_full);
         if (mdl_full) begin
            check("res_data", res_data, mdl_data);
            check("res_id", res_id, mdl_id);
            check("res_err", res_err, mdl_err);
         end
         if (res_valid && res_ready) begin
            q_data.push_back(res_data);
            q_id.push_back(int'(res_id));
            q_err.push_back(res_err);
         end
         if (exp_ready != 4'b0000) begin
            mdl_full = 1;
            mdl_data = model_shift(req_data[win*8 +: 8], int'(req_amt[win*3 +: 3]),
                                   req_dir[win], req_mode[win*2 +: 2]);
            mdl_id   = win;
            mdl_err  = (req_mode[win*2 +: 2] == 2'b11);
            mdl_ptr  = (win + 1) % NREQ;
         end else if (mdl_full && res_ready) begin
            mdl_full = 0;
         end
      end
   end

   task automatic set_payload(input int i, input logic [7:0] d, input int amt,
                              input bit dir, input logic [1:0] mode);
      req_data[i*8 +: 8] = d;
      req_amt[i*3 +: 3]  = 3'(amt);
      req_dir[i]         = dir;
      req_mode[i*2 +: 2] = mode;
   endtask

   task automatic send(input int i, input logic [7:0] d, input int amt,
                       input bit dir, input logic [1:0] mode);
      bit got;
      got = 0;
      set_payload(i, d, amt, dir, mode);
      req_valid    = '0;
      req_valid[i] = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (req_ready[i]) begin
            got = 1;
            break;
         end
      end
      check("send_accepted", got, 1);
      @(posedge clk);
      #1;
      req_valid[i] = 1'b0;
   endtask

   task automatic expect_res(input string name, input logic [7:0] d, input int id, input bit err);
      for (int c = 0; c < 10; c++) begin
         if (q_data.size() > 0) break;
         @(posedge clk);
         #1;
      end
      check({name, "_present"}, q_data.size() > 0, 1);
      if (q_data.size() > 0) begin
         check({name, "_data"}, q_data.pop_front(), d);
         check({name, "_id"}, q_id.pop_front(), id);
         check({name, "_err"}, q_err.pop_front(), err);
      end
   endtask

   int exp_ids[5];

   initial begin
      rst       = 1'b1;
      req_valid = '0;
      req_data  = '0;
      req_amt   = '0;
      req_dir   = '0;
      req_mode  = '0;
      res_ready = 1'b1;

      check("model_lsl", model_shift(8'hB6, 3, 1, 2'b00), 8'hB0);
      check("model_lsr", model_shift(8'hB6, 3, 0, 2'b00), 8'h16);
      check("model_asr", model_shift(8'hB6, 3, 0, 2'b01), 8'hF6);
      check("model_rol", model_shift(8'hB6, 3, 1, 2'b10), 8'hB5);
      check("model_ror", model_shift(8'hB6, 3, 0, 2'b10), 8'hD6);
      check("model_ill", model_shift(8'hB6, 5, 1, 2'b11), 8'hB6);

      // Requests presented while in reset must be ignored.
      repeat (2) @(posedge clk);
      #1 req_valid = 4'b1111;
      repeat (3) @(posedge clk);
      #1;
      req_valid = '0;
      rst       = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_no_result", q_data.size(), 0);

      send(0, 8'hB6, 3, 1, 2'b00); expect_res("lsl_r0", 8'hB0, 0, 0);
      send(2, 8'hB6, 3, 0, 2'b01); expect_res("asr_r2", 8'hF6, 2, 0);
      send(2, 8'hB6, 3, 1, 2'b10); expect_res("rol_r2", 8'hB5, 2, 0);
      send(1, 8'hB6, 5, 1, 2'b11); expect_res("ill_r1", 8'hB6, 1, 1);
      send(1, 8'hB6, 3, 1, 2'b00); expect_res("err_clr", 8'hB0, 1, 0);
      send(3, 8'hB6, 0, 0, 2'b01); expect_res("amt0_r3", 8'hB6, 3, 0);
      send(3, 8'hB6, 2, 1, 2'b01); expect_res("asl_r3", 8'hD8, 3, 0);
      send(0, 8'hB6, 3, 0, 2'b10); expect_res("ror_r0", 8'hD6, 0, 0);

      // Contention with the pointer freshly reset.
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      q_data.delete(); q_id.delete(); q_err.delete();
      for (int i = 0; i < NREQ; i++) set_payload(i, 8'(8'h11 * (i + 1)), i, 1, 2'b00);
      req_valid = 4'b1111;
      repeat (5) @(posedge clk);
      #1 req_valid = '0;
      repeat (3) @(posedge clk);
      #1;
`ifdef BSA_ROUND_ROBIN_EN
      exp_ids = '{0, 1, 2, 3, 0};
`else
      exp_ids = '{0, 0, 0, 0, 0};
`endif
      check("contend_count", q_id.size(), 5);
      for (int k = 0; k < 5; k++) begin
         if (q_id.size() > 0) check("contend_id", q_id.pop_front(), exp_ids[k]);
      end
      q_data.delete(); q_id.delete(); q_err.delete();

      // Backpressure: buffer full, consumer stalled for five cycles.
      res_ready = 1'b0;
      send(3, 8'hB6, 3, 1, 2'b00);
      set_payload(0, 8'hB6, 1, 0, 2'b00);
      req_valid = 4'b0001;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("stall_req_ready", req_ready, 4'b0000);
         check("stall_res_valid", res_valid, 1);
         check("stall_res_data", res_data, 8'hB0);
         check("stall_res_id", res_id, 3);
      end
      @(posedge clk);
      #1 res_ready = 1'b1;
      @(negedge clk);
      check("drain_accept_ready", req_ready, 4'b0001);
      check("drain_accept_valid", res_valid, 1);
      @(posedge clk);
      #1 req_valid = '0;
      expect_res("stall_first", 8'hB0, 3, 0);
      expect_res("stall_second", 8'h5B, 0, 0);

      // Reset while full discards the buffered result.
      q_data.delete(); q_id.delete(); q_err.delete();
      res_ready = 1'b0;
      send(1, 8'hB6, 3, 1, 2'b00);
      check("pre_rst_full", res_valid, 1);
      #1 rst = 1'b1;
      #1 check("rst_async_valid", res_valid, 0);
      @(posedge clk);
      #1;
      rst       = 1'b0;
      res_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("rst_discard", q_data.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/barrel_shift_arbiter.md
BARREL_SHIFT_ARBITER -- requirements
Module: barrel_shift_arbiter

Interface
REQ-001 Parameter N, default 8: data width in bits, power of two, minimum 4.
REQ-002 Parameter NREQ, default 4: number of requesters, 2 to 8.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  NREQ  per-requester request valid.
REQ-006 req_ready  output  NREQ  per-requester accept; at most one bit high per cycle.
REQ-007 req_data  input  NREQ*N  packed operands; requester i occupies bits [i*N +: N].
REQ-008 req_amt  input  NREQ*log2(N)  packed shift amounts.
REQ-009 req_dir  input  NREQ  shift direction; 1 = left, 0 = right.
REQ-010 req_mode  input  NREQ*2  per-requester mode: 00 logical, 01 arithmetic, 10 rotate, 11 illegal.
REQ-011 res_valid  output  1  result valid.
REQ-012 res_ready  input  1  consumer accept.
REQ-013 res_data  output  N  shifted result.
REQ-014 res_id  output  log2(NREQ)  index of the requester that produced the result.
REQ-015 res_err  output  1  high when the result came from mode 11.

Function
REQ-016 The block SHALL share one combinational shifter core among NREQ requesters and register its output in a one-entry result buffer.
REQ-017 Handshake rules: a request transfers when req_valid[i] and req_ready[i] are both high; the result transfers when res_valid and res_ready are both high.
REQ-018 Requesters SHALL hold req_valid and their payload stable until accepted; the block does not check this.
REQ-019 The FSM has two states. EMPTY moves to FULL on accept. FULL stays FULL on simultaneous drain and accept. FULL moves to EMPTY on a drain without an accept.
REQ-020 can_accept = EMPTY, or (FULL and res_ready).
REQ-021 req_ready SHALL be the combinational one-hot of the arbitration winner, gated by can_accept; it SHALL be all zeros when no req_valid bit is set.
REQ-022 Latency: res_valid SHALL rise on the edge that completes the request handshake; simultaneous drain and accept sustains one result per cycle.
REQ-023 Logical mode SHALL zero-fill; arithmetic right SHALL replicate the MSB; arithmetic left SHALL equal logical left; rotate SHALL wrap modulo N.
REQ-024 A shift amount of 0 SHALL pass the operand through unchanged in every mode.
REQ-025 Mode 11 SHALL pass the operand through unchanged and set res_err for that result.
REQ-026 While FULL and res_ready is low, res_data, res_id and res_err SHALL hold their values.

Reset
REQ-027 While rst is high: state EMPTY, res_valid=0, res_data=0, res_id=0, res_err=0, req_ready=0, priority pointer=0.
REQ-028 A reset asserted while FULL SHALL discard the buffered result with no handshake.
REQ-029 A request presented during reset SHALL NOT be accepted.

Configuration
REQ-030 Macro BSA_ROUND_ROBIN_EN defined: round-robin arbitration. The search starts at the pointer; on each accept the pointer moves to winner+1, modulo NREQ.
REQ-031 Macro BSA_ROUND_ROBIN_EN undefined: fixed priority, lowest index wins. The pointer register SHALL NOT be instantiated.

Structure
REQ-032 The shared package bsa_pkg SHALL hold the mode encodings (MODE_LOGIC, MODE_ARITH, MODE_ROT, MODE_ILLEGAL), the direction constants, and the FSM state typedef.
REQ-033 The shifter datapath SHALL be a sub-module named barrel_shift_core with ports d_in, sft_amt, sft_dir, mode and dout; arbitration, FSM and buffer stay in the top module.

Verification
REQ-034 Requester 0 sends d=10110110, amt=3, dir=1, mode=00, with res_ready=1 -> next cycle res_data=10110000, res_id=0, res_err=0.
REQ-035 Requester 2 sends d=10110110, amt=3, dir=0, mode=01 -> res_data=11110110, res_id=2; same operand with dir=1, mode=10 -> res_data=10110101.
REQ-036 All four requesters valid continuously, res_ready=1 -> with BSA_ROUND_ROBIN_EN, res_id sequence is 0,1,2,3,0 on consecutive cycles; without it, res_id stays 0.
REQ-037 Buffer FULL with res_ready=0 for 5 cycles -> req_ready=0000 and outputs held; res_ready rises -> drain and the next accept happen in the same cycle.
REQ-038 Mode 11 with d=10110110, amt=5 -> res_data=10110110, res_err=1; a subsequent mode-00 result -> res_err=0.
REQ-039 rst pulsed while FULL with res_ready=0 -> res_valid=0 immediately; no result is delivered for the discarded request.
